// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states, operation
// select and the bit-counter width helper.
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;
  typedef enum logic {OP_MULT, OP_DIV} op_e;

  localparam int unsigned MD_WIDTH_DEF = 32;
  localparam int unsigned MD_CNT_W     = $clog2(MD_WIDTH_DEF);

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: shift-add for multiply (LSB first),
// restoring subtract-and-shift for divide (MSB first) on the {acc, q} pair.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic           ge;

  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    sh  = {acc, q[WIDTH-1]};
    ge  = (sh >= {1'b0, b});
    if (op == OP_MULT) begin
      acc_nxt = sum[WIDTH:1];
      q_nxt   = {sum[0], q[WIDTH-1:1]};
    end else begin
      // when ge holds the true difference is below b, so modulo-2^W subtraction is exact
      acc_nxt = ge ? (sh[WIDTH-1:0] - b) : sh[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiply/divide, one bit per clock, WIDTH+1 cycle
// latency with a ready/busy handshake and registered outputs.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  input  logic             ctrl_HIGH,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  op_e                op_r;
  logic               signed_r, high_r, sgn_q_r, sgn_r_r, dz_r, ovf_r;
  logic [WIDTH-1:0]   acc, q, b, a_raw;
  logic [WIDTH-1:0]   acc_nxt, q_nxt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept;

  logic signed [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]          fix_result;
  logic                      fix_exc;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  function automatic logic signed [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] m,
                                                                input logic neg);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  // signed: top W+1 bits must be a pure sign extension; unsigned: high half must be zero
  function automatic logic mult_ovf(input logic signed [2*WIDTH-1:0] p, input logic sgn);
    if (sgn)
      return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
    return |p[2*WIDTH-1:WIDTH];
  endfunction

  assign accept = data_inputRDY & (ctrl_MULT ^ ctrl_DIV);
  assign mag_a  = magnitude(data_operandA, ctrl_SIGNED);
  assign mag_b  = magnitude(data_operandB, ctrl_SIGNED);

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .acc     (acc),
    .q       (q),
    .b       (b),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  // accept: latch magnitudes, mode and sign/exception flags; BUSY: iterate
  always_ff @(posedge clock) begin
    if (accept) begin
      op_r     <= ctrl_DIV ? OP_DIV : OP_MULT;
      signed_r <= ctrl_SIGNED;
      high_r   <= ctrl_HIGH;
      sgn_q_r  <= ctrl_SIGNED & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
      sgn_r_r  <= ctrl_SIGNED & data_operandA[WIDTH-1];
      dz_r     <= (data_operandB == '0);
      ovf_r    <= ctrl_SIGNED & (data_operandA == MIN_VAL) & (data_operandB == '1);
      a_raw    <= data_operandA;
      acc      <= '0;
      q        <= ctrl_DIV ? mag_a : mag_b;
      b        <= ctrl_DIV ? mag_b : mag_a;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      q   <= q_nxt;
    end
  end

  // FIX: sign correction, half/quotient/remainder select and exception
  always_comb begin
    prod_s     = apply_sign_wide({acc, q}, sgn_q_r);
    fix_result = '0;
    fix_exc    = 1'b0;
    if (op_r == OP_MULT) begin
      fix_result = high_r ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
      fix_exc    = !high_r && mult_ovf(prod_s, signed_r);
    end else if (dz_r) begin
      fix_result = high_r ? a_raw : '1;
      fix_exc    = 1'b1;
    end else if (ovf_r) begin
      fix_result = high_r ? '0 : MIN_VAL;
      fix_exc    = 1'b1;
    end else begin
      fix_result = high_r ? apply_sign(acc, sgn_r_r) : apply_sign(q, sgn_q_r);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_inputRDY  <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state          <= BUSY;
            cnt            <= CNT_LOAD;
            data_resultRDY <= 1'b0;
            data_inputRDY  <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          data_result    <= fix_result;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
          data_inputRDY  <= 1'b1;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
